// File: rtl/misr_bist_compactor.sv
// misr_bist_compactor: parametrised MISR signature compactor with BIST run control and golden compare.
// Optional serial scan access to the signature when MISR_SCAN_EN is defined.
module misr_bist_compactor #(
  parameter int NBIT = 16,
  parameter int NIN = 4,
  parameter logic [NBIT-1:0] POLY = 16'h002D,
  parameter logic [NBIT-1:0] SEED = '1,
  parameter int NCYC = 64,
  parameter logic [NBIT-1:0] GOLDEN = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NIN-1:0]  din,
  input  logic            din_valid,
  output logic [NBIT-1:0] signature,
  output logic            busy,
  output logic            done,
  output logic            pass,
  input  logic            scan_en,
  input  logic            scan_in,
  output logic            scan_out
);
  localparam int CW = $clog2(NCYC + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [NBIT-1:0] sig, d, step;
  logic fb;
  always_comb begin
    d = '0;
    d[NIN-1:0] = din;
    fb = sig[NBIT-1];
    // stage 0 always takes feedback; POLY bit 0 is masked off
    step = {sig[NBIT-2:0], fb} ^ ({POLY[NBIT-1:1], 1'b0} & {NBIT{fb}}) ^ d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= SEED;
      state <= IDLE;
      cnt <= '0;
      pass <= 1'b0;
    end else if (state != RUN && start) begin
      sig <= SEED;
      state <= RUN;
      cnt <= '0;
      pass <= 1'b0;
    end else if (state == RUN && din_valid) begin
      sig <= step;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(NCYC - 1)) begin
        state <= DONE;
        pass <= (step == GOLDEN);
      end
`ifdef MISR_SCAN_EN
    end else if (state != RUN && scan_en) begin
      sig <= {scan_in, sig[NBIT-1:1]};
`endif
    end
  end
  assign signature = sig;
  assign busy = state == RUN;
  assign done = state == DONE;
`ifdef MISR_SCAN_EN
  assign scan_out = sig[0];
`else
  logic unused_scan;
  assign unused_scan = scan_en ^ scan_in;
  assign scan_out = 1'b0;
`endif
endmodule

// File: tb/tb_misr_bist_compactor.sv
// tb_misr_bist_compactor: directed self-checking bench for misr_bist_compactor (4-bit, 1-input, NCYC=4).
module tb_misr_bist_compactor;
  logic clk = 1'b0;
  logic rst, start, din_valid, scan_en, scan_in;
  logic [0:0] din;
  logic [3:0] signature;
  logic busy, done, pass, scan_out;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  misr_bist_compactor #(
    .NBIT(4), .NIN(1), .POLY(4'b0011), .SEED(4'b0001), .NCYC(4), .GOLDEN(4'b0011)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .signature(signature), .busy(busy), .done(done), .pass(pass),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic b);
    din_valid = 1'b1;
    din = b;
    tick();
    din_valid = 1'b0;
    din = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    // 1: reset state
    chk("rst_sig", 32'(signature), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
`ifdef MISR_SCAN_EN
    chk("rst_scan_out", 32'(scan_out), 32'h1);
`else
    chk("rst_scan_out", 32'(scan_out), 32'h0);
`endif
    // din ignored in IDLE
    beat(1'b1);
    chk("idle_din_ignored", 32'(signature), 32'h1);
    // 2: clean run
    go();
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_seed", 32'(signature), 32'h1);
    beat(1'b0); chk("t2_b1", 32'(signature), 32'h2);
    beat(1'b0); chk("t2_b2", 32'(signature), 32'h4);
    beat(1'b0); chk("t2_b3", 32'(signature), 32'h8);
    chk("t2_not_done", 32'(done), 32'h0);
    beat(1'b0); chk("t2_b4", 32'(signature), 32'h3);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_pass", 32'(pass), 32'h1);
    chk("t2_busy_low", 32'(busy), 32'h0);
    beat(1'b1);
    chk("t2_done_hold", 32'(signature), 32'h3);
    // 3: error injected on beat 1 (start in DONE restarts)
    go();
    chk("t3_restart_pass", 32'(pass), 32'h0);
    beat(1'b1); chk("t3_b1", 32'(signature), 32'h3);
    beat(1'b0); chk("t3_b2", 32'(signature), 32'h6);
    beat(1'b0); chk("t3_b3", 32'(signature), 32'hC);
    beat(1'b0); chk("t3_b4", 32'(signature), 32'hB);
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_pass", 32'(pass), 32'h0);
    // 4: stall mid-run, start in RUN ignored
    go();
    beat(1'b0); beat(1'b0);
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      tick();
      chk("t4_freeze_sig", 32'(signature), 32'h4);
      chk("t4_freeze_busy", 32'(busy), 32'h1);
    end
    start = 1'b0;
    beat(1'b0);
    chk("t4_b3", 32'(signature), 32'h8);
    chk("t4_not_done", 32'(done), 32'h0);
    beat(1'b0);
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_pass", 32'(pass), 32'h1);
    // 5: reset mid-run, then rst wins over start
    go();
    beat(1'b0); beat(1'b0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("t5_rst_sig", 32'(signature), 32'h1);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_done", 32'(done), 32'h0);
    go();
    beat(1'b0); beat(1'b0); beat(1'b0); beat(1'b0);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_pass", 32'(pass), 32'h1);
`ifdef MISR_SCAN_EN
    // 6: scan unload/load in DONE
    begin
      logic [3:0] si, so;
      si = 4'b0101;
      so = 4'b0011;
      scan_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
        scan_in = si[i];
        chk("t6_scan_out", 32'(scan_out), 32'(so[i]));
        tick();
      end
      scan_en = 1'b0; scan_in = 1'b0;
      chk("t6_sig", 32'(signature), 32'h5);
      chk("t6_pass", 32'(pass), 32'h1);
      chk("t6_done", 32'(done), 32'h1);
    end
`else
    scan_en = 1'b1; scan_in = 1'b0;
    tick(); tick();
    scan_en = 1'b0;
    chk("noscan_sig", 32'(signature), 32'h3);
    chk("noscan_out", 32'(scan_out), 32'h0);
`endif
    go();
    chk("restart_pass_clr", 32'(pass), 32'h0);
    chk("restart_sig", 32'(signature), 32'h1);
    chk("restart_done_clr", 32'(done), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
